// File: rtl/aes128_key_schedule_ctrl.sv
// AES-128 key schedule sequencer: accepts a cipher key, expands it one round per
// cycle through a combinational expansion port, and serves round keys via a read port.

module aes128_key_expansion_port (
    input  logic [127:0] key,
    input  logic [3:0]   round_num,
    output logic [127:0] new_key
);
    // Forward S-box, row 0 in the most significant bits; byte b sits at [2047-8b -: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sub_byte(input logic [7:0] b);
        logic [10:0] idx;
        idx = 11'd2047 - {b, 3'b000};
        return SBOX[idx -: 8];
    endfunction

    logic [7:0]  rcon;
    logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

    always_comb begin
        case (round_num)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    always_comb begin
        w0   = key[127:96];
        w1   = key[95:64];
        w2   = key[63:32];
        w3   = key[31:0];
        temp = {sub_byte(w3[23:16]) ^ rcon, sub_byte(w3[15:8]),
                sub_byte(w3[7:0]), sub_byte(w3[31:24])};
        n0   = w0 ^ temp;
        n1   = w1 ^ n0;
        n2   = w2 ^ n1;
        n3   = w3 ^ n2;
        // Round numbers outside 1..10 have no schedule entry and yield zero.
        new_key = (round_num >= 4'd1 && round_num <= 4'd10) ? {n0, n1, n2, n3} : '0;
    end
endmodule

module aes128_key_schedule_ctrl (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic         clear,
    output logic         busy,
    output logic         keys_valid,
    input  logic         rk_rd_en,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data,
    output logic         rk_rd_valid
);
    typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

    state_t       state;
    logic [127:0] rk_bank [0:10];
    logic [127:0] wk;
    logic [3:0]   cnt;
    logic [127:0] new_key;

    aes128_key_expansion_port u_expand (
        .key       (wk),
        .round_num (cnt),
        .new_key   (new_key)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state       <= IDLE;
            wk          <= '0;
            cnt         <= '0;
            for (int i = 0; i < 11; i++) rk_bank[i] <= '0;
            // Held low while in reset, but a clear leaves the block ready for a key.
            key_ready   <= rst_n;
            busy        <= 1'b0;
            keys_valid  <= 1'b0;
            rk_rd_valid <= 1'b0;
            rk_data     <= '0;
        end else begin
            if (rk_rd_en && keys_valid) begin
                rk_rd_valid <= 1'b1;
                rk_data     <= (rk_addr <= 4'd10) ? rk_bank[rk_addr] : '0;
            end else if (rk_rd_en) begin
                rk_rd_valid <= 1'b0;
                rk_data     <= '0;
            end else begin
                rk_rd_valid <= 1'b0;
            end

            case (state)
                IDLE, READY: begin
                    key_ready <= 1'b1;
                    if (key_valid && key_ready) begin
                        rk_bank[0] <= key;
                        wk         <= key;
                        cnt        <= 4'd1;
                        state      <= EXPAND;
                        busy       <= 1'b1;
                        keys_valid <= 1'b0;
                        key_ready  <= 1'b0;
                    end
                end
                EXPAND: begin
                    rk_bank[cnt] <= new_key;
                    wk           <= new_key;
                    if (cnt == 4'd10) begin
                        cnt        <= 4'd0;
                        state      <= READY;
                        busy       <= 1'b0;
                        keys_valid <= 1'b1;
                        key_ready  <= 1'b1;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes128_key_schedule_ctrl.sv
// Self-checking bench: a word-level FIPS-197 key-expansion model with a cycle-level
// observable-behaviour model, compared on every cycle, plus directed literal checks.

module tb_aes128_key_schedule_ctrl;
    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] ZERO_KEY = 128'h0;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key;
    logic         key_valid;
    logic         key_ready;
    logic         clear;
    logic         busy;
    logic         keys_valid;
    logic         rk_rd_en;
    logic [3:0]   rk_addr;
    logic [127:0] rk_data;
    logic         rk_rd_valid;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int acc    = 0;

    always #5 clk = ~clk;

    aes128_key_schedule_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key         (key),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .clear       (clear),
        .busy        (busy),
        .keys_valid  (keys_valid),
        .rk_rd_en    (rk_rd_en),
        .rk_addr     (rk_addr),
        .rk_data     (rk_data),
        .rk_rd_valid (rk_rd_valid)
    );

    // GF(2^8) arithmetic and the S-box derived from the field inverse plus affine map.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_model(input logic [7:0] b);
        logic [7:0] inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gf_mul(inv, b);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_model(t[31:24]) ^ rc, sbox_model(t[23:16]),
                     sbox_model(t[15:8]), sbox_model(t[7:0])};
                rc = gf_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    // Observable-behaviour model, advanced on each rising edge from the inputs.
    logic [127:0] mdl_bank [11];
    logic [127:0] mdl_pending;
    logic [127:0] mdl_data;
    logic         mdl_kr, mdl_busy, mdl_kv, mdl_rdv;
    int           mdl_remaining = 0;
    bit           check_en = 1'b0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n || clear) begin
            mdl_kr        = rst_n;
            mdl_busy      = 1'b0;
            mdl_kv        = 1'b0;
            mdl_rdv       = 1'b0;
            mdl_data      = '0;
            mdl_remaining = 0;
            check_en      = 1'b1;
        end else begin
            if (rk_rd_en) begin
                mdl_rdv  = mdl_kv;
                mdl_data = (mdl_kv && rk_addr <= 4'd10) ? mdl_bank[rk_addr] : '0;
            end else begin
                mdl_rdv = 1'b0;
            end
            if (mdl_remaining > 0) begin
                mdl_remaining = mdl_remaining - 1;
                if (mdl_remaining == 0) begin
                    for (int i = 0; i < 11; i++) mdl_bank[i] = round_key(mdl_pending, i);
                    mdl_kv   = 1'b1;
                    mdl_busy = 1'b0;
                    mdl_kr   = 1'b1;
                end
            end else if (key_valid && mdl_kr) begin
                mdl_pending   = key;
                mdl_remaining = 10;
                mdl_busy      = 1'b1;
                mdl_kv        = 1'b0;
                mdl_kr        = 1'b0;
            end else begin
                mdl_kr = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("cyc_key_ready",   128'(key_ready),   128'(mdl_kr));
            checkOutput("cyc_busy",        128'(busy),        128'(mdl_busy));
            checkOutput("cyc_keys_valid",  128'(keys_valid),  128'(mdl_kv));
            checkOutput("cyc_rk_rd_valid", 128'(rk_rd_valid), 128'(mdl_rdv));
            checkOutput("cyc_rk_data",     rk_data,           mdl_data);
        end
    end

    task automatic applyStimulus(input logic r, input logic kv, input logic [127:0] k,
                                 input logic clr, input logic rde, input logic [3:0] a);
        rst_n     = r;
        key_valid = kv;
        key       = k;
        clear     = clr;
        rk_rd_en  = rde;
        rk_addr   = a;
        @(negedge clk);
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0, 4'd0);
    endtask

    task automatic loadKey(input logic [127:0] k);
        bit done = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            done = key_ready;
            applyStimulus(1'b1, 1'b1, k, 1'b0, 1'b0, 4'd0);
        end
        acc = cyc;
        if (!done) checkOutput("load_timeout", 128'(0), 128'(1));
        key_valid = 1'b0;
    endtask

    task automatic waitKeysValid(input string name);
        int n = 0;
        while (!keys_valid && n < 30) begin
            idleCycle();
            n++;
        end
        checkOutput(name, 128'(cyc - acc + 1), 128'(11));
    endtask

    task automatic readKey(input string name, input logic [3:0] a, input logic [127:0] exp_data,
                           input logic exp_valid);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, a);
        checkOutput({name, "_valid"}, 128'(rk_rd_valid), 128'(exp_valid));
        checkOutput({name, "_data"}, rk_data, exp_data);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int held;

        checkOutput("model_fips_rk1",  round_key(FIPS_KEY, 1),  128'ha0fafe1788542cb123a339392a6c7605);
        checkOutput("model_fips_rk10", round_key(FIPS_KEY, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        checkOutput("model_zero_rk1",  round_key(ZERO_KEY, 1),  128'h62636363626363636263636362636363);
        checkOutput("model_zero_rk10", round_key(ZERO_KEY, 10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, FIPS_KEY, 1'b0, 1'b0, 4'd0);
        checkOutput("reset_key_ready",  128'(key_ready),  128'(0));
        checkOutput("reset_keys_valid", 128'(keys_valid), 128'(0));
        checkOutput("reset_busy",       128'(busy),       128'(0));
        checkOutput("reset_rk_data",    rk_data,          '0);
        idleCycle();
        checkOutput("release_key_ready", 128'(key_ready), 128'(1));

        loadKey(FIPS_KEY);
        checkOutput("load_busy", 128'(busy), 128'(1));
        waitKeysValid("fips_latency");
        readKey("fips_addr0",  4'd0,  FIPS_KEY, 1'b1);
        readKey("fips_addr1",  4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b1);
        readKey("fips_addr10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
        readKey("bound_addr11", 4'd11, '0, 1'b1);
        readKey("bound_addr15", 4'd15, '0, 1'b1);
        for (int i = 0; i <= 10; i++) readKey("stream", 4'(i), round_key(FIPS_KEY, i), 1'b1);
        idleCycle();

        applyStimulus(1'b1, 1'b1, ZERO_KEY, 1'b0, 1'b1, 4'd1);
        acc = cyc;
        checkOutput("rekey_old_read", rk_data, 128'ha0fafe1788542cb123a339392a6c7605);
        checkOutput("rekey_kv_drop", 128'(keys_valid), 128'(0));
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1, 4'd1);
        checkOutput("rekey_window_read", 128'(rk_rd_valid), 128'(0));
        waitKeysValid("rekey_latency");
        readKey("zero_addr10", 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b1);

        loadKey(FIPS_KEY);
        held = 0;
        while (!key_ready && held < 30) begin
            applyStimulus(1'b1, 1'b1, ZERO_KEY, 1'b0, 1'b0, 4'd0);
            held++;
        end
        checkOutput("hold_cycles", 128'(held), 128'(10));
        applyStimulus(1'b1, 1'b1, ZERO_KEY, 1'b0, 1'b1, 4'd10);
        acc = cyc;
        checkOutput("hold_first_intact", rk_data, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        key_valid = 1'b0;
        waitKeysValid("hold_second_latency");
        readKey("hold_second_addr10", 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 1'b1);

        loadKey(FIPS_KEY);
        for (int i = 0; i < 4; i++) idleCycle();
        applyStimulus(1'b1, 1'b1, ZERO_KEY, 1'b1, 1'b0, 4'd0);
        checkOutput("clear_busy",       128'(busy),       128'(0));
        checkOutput("clear_keys_valid", 128'(keys_valid), 128'(0));
        checkOutput("clear_key_ready",  128'(key_ready),  128'(1));
        readKey("clear_read", 4'd0, '0, 1'b0);
        loadKey(FIPS_KEY);
        waitKeysValid("reload_latency");
        readKey("reload_addr1",  4'd1,  128'ha0fafe1788542cb123a339392a6c7605, 1'b1);
        readKey("reload_addr10", 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b1);
        idleCycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aes128_key_schedule_ctrl.md
# aes128_key_schedule_ctrl

Sequencer for the AES-128 key schedule. It accepts a cipher key over a valid/ready handshake and iterates the combinational `aes128_key_expansion_port` once per cycle with round_num 1..10. The 11 round keys are stored in an internal bank and served to the round datapath through a registered read port. It sits between the key-load interface and the encrypt/decrypt round cores.

## Interface

Parameters
- none. Widths come from `aes_defines.svh`: `AES128_KEY_SIZE` = 128, `AES128_ROUNDS_NUM` = 10.

Ports
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  reset. Synchronous, active-low.
- key  in  128  cipher key. Byte order follows `aes_defines.svh`.
- key_valid  in  1  key offered.
- key_ready  out  1  key accepted when key_valid && key_ready.
- clear  in  1  zeroize request, one cycle.
- busy  out  1  expansion in progress.
- keys_valid  out  1  all 11 round keys stored and stable.
- rk_rd_en  in  1  round-key read request.
- rk_addr  in  4  round-key index, 0..10.
- rk_data  out  128  read data.
- rk_rd_valid  out  1  rk_data valid this cycle.

## Operation

- Instantiates one `aes128_key_expansion_port`. Its `key` input is the internal work register `wk`; its `round_num` input is the 4-bit counter `cnt`.
- Storage: `rk_bank[0..10]` (11×128 flops), `wk` (128), `cnt` (4), plus state.

FSM states: IDLE, EXPAND, READY.
- **IDLE:** key_ready=1. On handshake: rk_bank[0]<=key, wk<=key, cnt<=1, go to EXPAND.
- **EXPAND:** key_ready=0, busy=1. Each cycle: rk_bank[cnt]<=new_key, wk<=new_key, cnt<=cnt+1. When cnt==10 is written, cnt<=0, keys_valid<=1, go to READY.
- **READY:** key_ready=1, keys_valid=1. A new handshake behaves as in IDLE, with keys_valid<=0 in the same edge. Old keys are unreadable from the next cycle.

Clear and reset:
- **clear:** in any state, takes priority over a handshake. Go to IDLE; zero rk_bank, wk and cnt; keys_valid<=0, rk_rd_valid<=0, rk_data<=0.
- **rst_n=0:** same effect as clear. Also applies mid-EXPAND; a partially expanded schedule is discarded.

Round-key read:
- Sampled when rk_rd_en=1.
- keys_valid=1 and rk_addr≤10: next cycle rk_data=rk_bank[rk_addr], rk_rd_valid=1.
- rk_addr 11..15: rk_data=0, rk_rd_valid=1.
- keys_valid=0: rk_data=0, rk_rd_valid=0. Request dropped, no queuing.
- rk_rd_en=0: rk_rd_valid=0; rk_data holds its last value.
- A read in the same cycle as a new-key handshake in READY returns the old key; this is the last permitted read.

Datapath rules:
- cnt is never 0 while in EXPAND, so the expansion port's zero-output path is never stored.
- cnt never exceeds 10.

## Timing

- Reset values: key_ready=0 during reset, 1 in the first cycle after reset release. busy=0, keys_valid=0, rk_data=0, rk_rd_valid=0, cnt=0, bank zero.
- Handshake accepted in cycle T:
  - busy=1 in cycles T+1..T+10.
  - rk_bank[n] written at the end of cycle T+n.
  - busy=0 and keys_valid=1 in cycle T+11.
  - key_ready is low in T+1..T+10 and high again in T+11.
- Acceptance-to-keys_valid latency: 11 cycles.
- Back-to-back keys: earliest second acceptance is cycle T+11. Total throughput is one key per 11 cycles.
- Read latency: 1 cycle. A read can be issued every cycle.
- clear asserted in cycle C: all outputs at reset values in C+1, except key_ready=1 (IDLE). A key_valid present in C is ignored.

## Test plan

- **Reset:** hold rst_n=0 for 3 cycles with key_valid=1 → no acceptance, all outputs zero. key_ready=1 in the first cycle after release.
- **FIPS-197 A.1 key:** load 2b7e151628aed2a6abf7158809cf4f3c → keys_valid exactly 11 cycles after acceptance. Reads then return:
  - addr0 = the key
  - addr1 = a0fafe1788542cb123a339392a6c7605
  - addr10 = d014f9a8c9ee2589e13f0cc8b6630ca6
  - each with rk_rd_valid one cycle after rk_rd_en.
- **Rekey in READY:** offer the all-zero key while keys_valid=1 → keys_valid drops the next cycle and a read in that window has rk_rd_valid=0. After 11 cycles, addr10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- **Key offered mid-expansion:** hold key_valid during EXPAND → key_ready stays 0 and no new key is taken until cycle T+11. The first key's schedule completes intact.
- **Clear mid-expansion:** assert clear at T+5 → busy=0 and keys_valid=0 at T+6. A subsequent read gives rk_rd_valid=0, and a reload yields a correct schedule.
- **Read bounds:**
  - rk_addr=11 and rk_addr=15 with keys_valid=1 → rk_data=0, rk_rd_valid=1.
  - Reads issued every cycle for addr 0..10 in sequence → correct data at one-cycle latency throughout.
